vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   Pixel-timing generator for the 640x480@60 Hz VGA path. Divides the board clock
//   into a pixel-enable tick and runs the horizontal/vertical scan counters.
//   Drives HCount/VCount into the object/text renderers, and hsync/vsync/video_on
//   to the RGB output stage. Directly upstream of every HCount/VCount consumer.
// PARAMETERS
//   CLK_DIV    4    board clocks per pixel (100 MHz -> 25 MHz); legal 1..16
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines
//   SYNC_POL   0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   board clock, all logic on rising edge
//   reset        in   1   synchronous, active-high reset
//   HCount       out  10  current pixel column, 0..H_TOTAL-1
//   VCount       out  10  current line, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, level per SYNC_POL
//   vsync        out  1   vertical sync, level per SYNC_POL
//   video_on     out  1   1 when HCount<H_DISPLAY and VCount<V_DISPLAY
//   p_tick       out  1   one-clk pixel-enable pulse, every CLK_DIV clks
//   frame_start  out  1   one-clk pulse on the tick that wraps to (0,0)
// BEHAVIOUR
//   - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Elaboration error if
//     either exceeds 1024 or CLK_DIV outside 1..16.
//   - Reset (sync, next rising edge, also mid-frame): divider=0, HCount=0, VCount=0,
//     p_tick=0, frame_start=0, hsync=vsync=~SYNC_POL. video_on then reads 1.
//   - Divider: counts 0..CLK_DIV-1; p_tick=1 for the clk where divider==CLK_DIV-1.
//     CLK_DIV=1 -> p_tick constantly 1 after reset is released.
//   - Counters advance only on clocks where p_tick=1:
//     HCount==H_TOTAL-1 -> HCount=0 and VCount increments on the same edge;
//     VCount==V_TOTAL-1 at that line wrap -> VCount=0. Otherwise HCount+1.
//   - hsync/vsync registered from next-state counters so they align with the
//     HCount/VCount they describe (zero skew, no extra pipeline delay):
//     hsync asserted iff HCount in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]
//     = [656,751]; vsync asserted iff VCount in [490,491].
//   - video_on combinational from registered HCount/VCount (no latency).
//   - frame_start: registered, high one clk, on the edge where counters go
//     (H_TOTAL-1,V_TOTAL-1)->(0,0); never more than once per frame.
//   - All comparisons unsigned 10-bit; no intermediate overflow permitted.
// STRUCTURE
//   - Shared package vga_timing_pkg: H_*/V_* default constants, H_TOTAL/V_TOTAL,
//     sync start/end derived constants; reused by renderers for region checks.
//   - One sub-module: pixel_tick_div (CLK_DIV counter -> p_tick). Scan counters,
//     sync decode and frame_start stay in vga_sync_gen.
// TESTING
//   1. Release reset, CLK_DIV=4 -> first p_tick at 4th clk; HCount=1 after it;
//      HCount steps every 4 clks thereafter.
//   2. Run one line -> hsync low exactly 96 ticks, first low with HCount=656,
//      high again at HCount=752; stays high on other HCount values.
//   3. At HCount=799,VCount=10 tick -> HCount=0,VCount=11 same edge; at (799,524)
//      -> (0,0) and frame_start high for exactly 1 clk.
//   4. video_on=1 for HCount 0..639, 0 at 640..799; 0 for all of VCount 480..524;
//      vsync low only for VCount 490..491 (1600 ticks).
//   5. Assert reset at HCount=300,VCount=200 mid-tick -> next edge all counters 0,
//      hsync=vsync=1, p_tick=0; resumes counting cleanly after release.
//   6. Two consecutive frame_start pulses -> exactly 1,680,000 clks apart
//      (800*525*4); repeat with CLK_DIV=1 -> 420,000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the sync generator and the
// renderers that need region checks on HCount/VCount.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Inclusive unsigned 10-bit window test.
  function automatic logic in_window(input logic [9:0] x, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Board-clock divider producing a registered one-clock pixel-enable pulse
// every CLK_DIV clocks.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  logic [3:0] div;
  logic [3:0] div_next;

  assign div_next = (div == LAST) ? 4'd0 : div + 4'd1;

  // p_tick is registered so it stays low during reset even when CLK_DIV==1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= 4'd0;
      p_tick <= 1'b0;
    end else begin
      div    <= div_next;
      p_tick <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters, sync decode and frame-start pulse, advanced by the
// pixel-enable tick from pixel_tick_div.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY_P  = H_DISPLAY,
  parameter int H_FRONT_P    = H_FRONT,
  parameter int H_SYNC_P     = H_SYNC,
  parameter int H_BACK_P     = H_BACK,
  parameter int V_DISPLAY_P  = V_DISPLAY,
  parameter int V_FRONT_P    = V_FRONT,
  parameter int V_SYNC_P     = V_SYNC,
  parameter int V_BACK_P     = V_BACK,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int HT = H_DISPLAY_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
  localparam int VT = V_DISPLAY_P + V_FRONT_P + V_SYNC_P + V_BACK_P;

  if (HT > 1024 || VT > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_param_err
    $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV in 1..16");
  end

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY_P);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY_P);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY_P + H_FRONT_P);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY_P + H_FRONT_P + H_SYNC_P - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY_P + V_FRONT_P);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY_P + V_FRONT_P + V_SYNC_P - 1);

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_wrap = (HCount == H_LAST);
    v_wrap = (VCount == V_LAST);
    h_next = HCount;
    v_next = VCount;
    if (p_tick) begin
      h_next = h_wrap ? 10'd0 : HCount + 10'd1;
      if (h_wrap) v_next = v_wrap ? 10'd0 : VCount + 10'd1;
    end
  end

  // Syncs decode the next-state counters so they land on the same edge as
  // the HCount/VCount values they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      HCount      <= 10'd0;
      VCount      <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      HCount      <= h_next;
      VCount      <= v_next;
      hsync       <= in_window(h_next, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_window(v_next, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      frame_start <= p_tick && h_wrap && v_wrap;
    end
  end

  assign video_on = (HCount < H_VIS) && (VCount < V_VIS);

endmodule
